// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and defaults for the Booth multiplier
package booth_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth add/sub step followed by arithmetic shift right
module booth_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH:0]   m_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_m1_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q_m1_out
);

    logic             do_op;
    logic             sub;
    logic [WIDTH:0]   operand;
    logic [WIDTH:0]   sum;

    // Booth recode on {Q[0], q_m1}, add/sub as A + (M ^ sub) + sub, then ASR of {A, Q, q_m1}
    always_comb begin
        do_op    = q_in[0] ^ q_m1_in;
        sub      = q_in[0] & ~q_m1_in;
        operand  = do_op ? (m_in ^ {(WIDTH + 1){sub}}) : '0;
        sum      = a_in + operand + {{WIDTH{1'b0}}, sub};
        a_out    = {sum[WIDTH], sum[WIDTH:1]};
        q_out    = {sum[0], q_in[WIDTH-1:1]};
        q_m1_out = q_in[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential signed radix-2 Booth multiplier with start/busy/done
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       step_a;
    logic [WIDTH-1:0]     step_q;
    logic                 step_qm1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_in     (a_q),
        .m_in     (m_q),
        .q_in     (q_q),
        .q_m1_in  (qm1_q),
        .a_out    (step_a),
        .q_out    (step_q),
        .q_m1_out (step_qm1)
    );

    // State register; reset returns to IDLE even mid-run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only matters in IDLE, DONE lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath next values: load operands on accept, step while running, latch product on last step
    always_comb begin
        cnt_d     = cnt_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        product_d = product_q;
        if (state_q == IDLE && start) begin
            a_d   = '0;
            m_d   = {multiplicand[WIDTH-1], multiplicand};
            q_d   = multiplier;
            qm1_d = 1'b0;
            cnt_d = CW'(WIDTH);
        end else if (state_q == RUN) begin
            a_d   = step_a;
            q_d   = step_q;
            qm1_d = step_qm1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                product_d = {step_a[WIDTH-1:0], step_q};
            end
        end
    end

    // Datapath registers; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            product_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier
module tb_booth_multiplier;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks;
    int failures;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic [2*W-1:0]      exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int r;
        r = int'(a) * int'(b);
        return r[2*W-1:0];
    endfunction

    // Issue one operation from IDLE, wait for done; returns product and edges from accept to done
    task automatic run_mult(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                            output logic [2*W-1:0] p, output int lat);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        p = product;
    endtask

    vec_t vecs[5];
    logic [2*W-1:0] p;
    logic [2*W-1:0] held;
    int lat;
    int ex_err;
    int accepts[$];
    logic [2*W-1:0] prods[$];
    logic prev_busy;
    int seen_done;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;

        vecs[0] = '{a: 4'sd3,  b: 4'sd5,  exp: 8'h0F};
        vecs[1] = '{a: -4'sd8, b: -4'sd8, exp: 8'h40};
        vecs[2] = '{a: -4'sd8, b: 4'sd7,  exp: 8'hC8};
        vecs[3] = '{a: 4'sd7,  b: -4'sd1, exp: 8'hF9};
        vecs[4] = '{a: 4'sd0,  b: -4'sd8, exp: 8'h00};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_product", 32'(product), 32'h00);
        end

        // busy right after accept, done latency, one-cycle done pulse
        @(negedge clk);
        multiplicand = 4'sd3;
        multiplier = 4'sd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("done_not_in_run", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("first_latency", 32'(lat), 32'(W));
        check("first_busy_in_done", 32'(busy), 32'd1);
        check("first_product", 32'(product), 32'h0F);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);

        // directed table
        for (int i = 0; i < 5; i++) begin
            run_mult(vecs[i].a, vecs[i].b, p, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
            check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].exp));
            held = p;
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_done_low", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_held", i), 32'(product), 32'(held));
        end

        // random operands vs reference
        for (int i = 0; i < 40; i++) begin
            logic signed [W-1:0] ra;
            logic signed [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            run_mult(ra, rb, p, lat);
            check($sformatf("rand_%0d_%0d", ra, rb), 32'(p), 32'(ref_mul(ra, rb)));
        end

        // start held high: back-to-back runs, operands changed mid-run ignored
        @(negedge clk);
        multiplicand = 4'sd2;
        multiplier = 4'sd3;
        start = 1'b1;
        prev_busy = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy && !prev_busy) accepts.push_back(c);
            if (done) prods.push_back(product);
            if (accepts.size() == 1 && c == accepts[0] + 2) begin
                multiplicand = -4'sd3;
                multiplier = 4'sd5;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check("b2b_accept_count", 32'(accepts.size() >= 2), 32'd1);
        check("b2b_prod_count", 32'(prods.size() >= 2), 32'd1);
        if (accepts.size() >= 2)
            check("b2b_spacing", 32'(accepts[1] - accepts[0]), 32'(W + 2));
        if (prods.size() >= 2) begin
            check("b2b_prod0", 32'(prods[0]), 32'h06);
            check("b2b_prod1", 32'(prods[1]), 32'hF1);
        end
        lat = 0;
        while (busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_drain", 32'(busy), 32'd0);
        check("b2b_last_nonzero", 32'(product), 32'hF1);

        // reset mid-run discards the result
        @(negedge clk);
        multiplicand = -4'sd7;
        multiplier = 4'sd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_product", 32'(product), 32'h00);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("midreset_no_done", 32'(seen_done), 32'd0);
        run_mult(4'sd2, -4'sd3, p, lat);
        check("after_reset_product", 32'(p), 32'hFA);

        // exhaustive sweep
        ex_err = 0;
        for (int a = -8; a <= 7; a++) begin
            for (int b = -8; b <= 7; b++) begin
                logic signed [W-1:0] ea;
                logic signed [W-1:0] eb;
                int f0;
                ea = W'(a);
                eb = W'(b);
                f0 = failures;
                run_mult(ea, eb, p, lat);
                check($sformatf("exh_%0d_%0d", a, b), 32'(p), 32'(ref_mul(ea, eb)));
                if (failures != f0) ex_err++;
            end
        end
        if (ex_err == 0) $display("Pass all test");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
